// File: rtl/rc6_pkg.sv
// Shared RC6 constants, derived sizes and the key-expander FSM state type.
package rc6_pkg;

    localparam int ROUNDS    = 20;
    localparam int S_WORDS   = 2 * ROUNDS + 4;
    localparam int KEY_WORDS = 8;
    localparam int MIX_STEPS = 3 * ((S_WORDS > KEY_WORDS) ? S_WORDS : KEY_WORDS);
    localparam int CNT_W     = 8;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        MIX,
        DONE
    } state_t;

endpackage

// File: rtl/rc6_rotl32.sv
// 32-bit rotate-left by a 5-bit amount; an amount of 0 passes the word through.
module rc6_rotl32 (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    // A right shift by 32 yields 0, so amt==0 collapses to din.
    assign dout = (din << amt) | (din >> (6'd32 - {1'b0, amt}));

endmodule

// File: rtl/rc6_key_expander.sv
// RC6 key-schedule sequencer: clears and loads the key register, then issues
// one S/L word update per cycle for the mixing loop and flags the subkeys valid.
module rc6_key_expander
    import rc6_pkg::*;
(
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inStart,
    input  logic [255:0] inKey,
    input  logic [31:0]  inSregValue,
    input  logic [31:0]  inLregValue,
    input  logic [31:0]  inAdata,
    input  logic [31:0]  inBdata,
    output logic         outRegClear,
    output logic         outExtWr,
    output logic [255:0] outExtKey,
    output logic         outIntWr,
    output logic [31:0]  outSvalue,
    output logic [31:0]  outLvalue,
    output logic         outBusy,
    output logic         outDone,
    output logic         outKeyValid
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   step_cnt;
    logic [255:0]       ext_key;
    logic               key_valid;

    logic [31:0]        s_sum, s_rot, ab_sum, l_sum, l_rot;

    always_ff @(posedge inClk) begin
        if (inReset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            ext_key   <= '0;
            key_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && inStart) begin
                ext_key   <= inKey;
                key_valid <= 1'b0;
            end
            if (state == DONE) begin
                key_valid <= 1'b1;
            end
            if (state == LOAD) begin
                step_cnt <= '0;
            end else if (state == MIX) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inStart) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD:    state_nxt = MIX;
            MIX:     if (step_cnt == CNT_W'(MIX_STEPS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle mixing step; the key register supplies S[i], L[j], A and B.
    assign s_sum  = inSregValue + inAdata + inBdata;

    rc6_rotl32 u_rotl_s (
        .din  (s_sum),
        .amt  (5'd3),
        .dout (s_rot)
    );

    assign ab_sum = s_rot + inBdata;
    assign l_sum  = inLregValue + ab_sum;

    rc6_rotl32 u_rotl_l (
        .din  (l_sum),
        .amt  (ab_sum[4:0]),
        .dout (l_rot)
    );

    assign outRegClear = (state == CLEAR);
    assign outExtWr    = (state == LOAD);
    assign outIntWr    = (state == MIX);
    assign outDone     = (state == DONE);
    assign outBusy     = (state == CLEAR) || (state == LOAD) || (state == MIX);
    assign outExtKey   = ext_key;
    assign outKeyValid = key_valid;
    assign outSvalue   = outIntWr ? s_rot : 32'd0;
    assign outLvalue   = outIntWr ? l_rot : 32'd0;

endmodule

// File: tb/tb_rc6_key_expander.sv
// Directed bench for rc6_key_expander with a behavioural key register and a
// reference RC6-32/20/32 key schedule.
module tb_rc6_key_expander;

    localparam logic [31:0]  P32  = 32'hB7E15163;
    localparam logic [31:0]  Q32  = 32'h9E3779B9;
    localparam logic [255:0] KEY0 = 256'h0;
    localparam logic [255:0] KEY2 = 256'h0123456789ABCDEF112233445566778899AABBCCDDEEFF01122334455667788;
    localparam logic [255:0] KEY3 = 256'hF0E1D2C3B4A5968778695A4B3C2D1E0F0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [255:0] KEYX = {32{8'hA5}};

    logic         inClk = 1'b0;
    logic         inReset, inStart;
    logic [255:0] inKey;
    logic [31:0]  inSregValue, inLregValue, inAdata, inBdata;
    logic         outRegClear, outExtWr, outIntWr, outBusy, outDone, outKeyValid;
    logic [255:0] outExtKey;
    logic [31:0]  outSvalue, outLvalue;

    int n_cmp = 0;
    int n_bad = 0;

    // Key register model and input override used for the rotate corner cases.
    logic [31:0] m_s [44];
    logic [31:0] m_l [8];
    logic [31:0] m_a, m_b;
    int          m_i, m_j;
    logic        force_en = 1'b0;
    logic [31:0] f_s, f_l, f_a, f_b;
    logic [31:0] exp_s [44];

    always #5 inClk = ~inClk;

    rc6_key_expander dut (
        .inClk       (inClk),
        .inReset     (inReset),
        .inStart     (inStart),
        .inKey       (inKey),
        .inSregValue (inSregValue),
        .inLregValue (inLregValue),
        .inAdata     (inAdata),
        .inBdata     (inBdata),
        .outRegClear (outRegClear),
        .outExtWr    (outExtWr),
        .outExtKey   (outExtKey),
        .outIntWr    (outIntWr),
        .outSvalue   (outSvalue),
        .outLvalue   (outLvalue),
        .outBusy     (outBusy),
        .outDone     (outDone),
        .outKeyValid (outKeyValid)
    );

    assign inSregValue = force_en ? f_s : m_s[m_i];
    assign inLregValue = force_en ? f_l : m_l[m_j];
    assign inAdata     = force_en ? f_a : m_a;
    assign inBdata     = force_en ? f_b : m_b;

    function automatic logic [31:0] key_word(input logic [255:0] k, input int j);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = k[255 - 8*(4*j + b) -: 8];
        return w;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    always @(posedge inClk) begin
        if (inReset || outRegClear) begin
            for (int k = 0; k < 44; k++) m_s[k] <= P32 + 32'(k) * Q32;
            for (int k = 0; k < 8; k++)  m_l[k] <= 32'd0;
            m_a <= 32'd0;
            m_b <= 32'd0;
            m_i <= 0;
            m_j <= 0;
        end else if (outExtWr) begin
            for (int k = 0; k < 8; k++) m_l[k] <= key_word(outExtKey, k);
        end else if (outIntWr && !force_en) begin
            m_s[m_i] <= outSvalue;
            m_l[m_j] <= outLvalue;
            m_a      <= outSvalue;
            m_b      <= outLvalue;
            m_i      <= (m_i == 43) ? 0 : m_i + 1;
            m_j      <= (m_j == 7) ? 0 : m_j + 1;
        end
    end

    task automatic compute_expected(input logic [255:0] key);
        logic [31:0] s [44];
        logic [31:0] l [8];
        logic [31:0] a, b;
        int i, j;
        s[0] = P32;
        for (int k = 1; k < 44; k++) s[k] = s[k-1] + Q32;
        for (int k = 0; k < 8; k++) l[k] = key_word(key, k);
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 132; k++) begin
            a = rotl(s[i] + a + b, 3);
            s[i] = a;
            b = rotl(l[j] + a + b, int'((a + b) & 32'd31));
            l[j] = b;
            i = (i + 1) % 44;
            j = (j + 1) % 8;
        end
        for (int k = 0; k < 44; k++) exp_s[k] = s[k];
    endtask

    task automatic test_reset();
        inReset = 1'b1; inStart = 1'b0; inKey = KEY2;
        repeat (3) @(negedge inClk);
        inReset = 1'b0;
        @(negedge inClk);
        n_cmp++;
        if ({outRegClear, outExtWr, outIntWr, outBusy, outDone, outKeyValid} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {outRegClear, outExtWr, outIntWr, outBusy, outDone, outKeyValid});
        end
        n_cmp++;
        if (outExtKey !== 256'h0 || outSvalue !== 32'h0 || outLvalue !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got key %h s %h l %h, want all zero", outExtKey, outSvalue, outLvalue);
        end
    endtask

    task automatic test_start_under_reset();
        inReset = 1'b1; inStart = 1'b1; inKey = KEY2;
        @(negedge inClk);
        inReset = 1'b0; inStart = 1'b0;
        @(negedge inClk);
        n_cmp++;
        if (outBusy !== 1'b0 || outRegClear !== 1'b0 || outExtKey !== 256'h0) begin
            n_bad++;
            $display("FAIL start_under_reset: got busy %b clear %b key %h, want 0 0 0", outBusy, outRegClear, outExtKey);
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge of cycle N+136.
    task automatic run_expansion(input logic [255:0] key, input int inject_k, input logic chk_first);
        int n_clear = 0, clear_k = 0, n_ext = 0, ext_k = 0, n_int = 0, first_int = 0, last_int = 0;
        int n_done = 0, done_k = 0, gate_err = 0;
        inKey = key; inStart = 1'b1;
        @(negedge inClk);
        for (int k = 1; k <= 135; k++) begin
            inStart = 1'b0;
            if (outRegClear) begin n_clear++; clear_k = k; end
            if (outExtWr) begin n_ext++; ext_k = k; end
            if (outIntWr) begin
                n_int++;
                if (first_int == 0) first_int = k;
                last_int = k;
            end
            if (outDone) begin n_done++; done_k = k; end
            if (!outIntWr && (outSvalue !== 32'h0 || outLvalue !== 32'h0)) gate_err++;
            if (k == 1) begin
                n_cmp++;
                if (outKeyValid !== 1'b0 || outExtKey !== key) begin
                    n_bad++;
                    $display("FAIL start_latch: got valid %b key %h, want 0 %h", outKeyValid, outExtKey, key);
                end
            end
            if (k == 3 && chk_first) begin
                n_cmp++;
                if (outSvalue !== 32'hBF0A8B1D || outLvalue !== 32'hB7E15163) begin
                    n_bad++;
                    $display("FAIL first_step: got s %h l %h, want bf0a8b1d b7e15163", outSvalue, outLvalue);
                end
            end
            if (inject_k > 0 && k == inject_k + 1) begin
                n_cmp++;
                if (outExtKey !== key || outBusy !== 1'b1 || outRegClear !== 1'b0) begin
                    n_bad++;
                    $display("FAIL start_during_mix: got key %h busy %b clear %b, want %h 1 0",
                             outExtKey, outBusy, outRegClear, key);
                end
            end
            if (inject_k > 0 && k == inject_k) begin
                inStart = 1'b1; inKey = KEYX;
            end
            @(negedge inClk);
        end
        n_cmp++;
        if (n_clear != 1 || clear_k != 1) begin
            n_bad++;
            $display("FAIL clear_pulse: got %0d pulses at %0d, want 1 at 1", n_clear, clear_k);
        end
        n_cmp++;
        if (n_ext != 1 || ext_k != 2) begin
            n_bad++;
            $display("FAIL extwr_pulse: got %0d pulses at %0d, want 1 at 2", n_ext, ext_k);
        end
        n_cmp++;
        if (n_int != 132 || first_int != 3 || last_int != 134) begin
            n_bad++;
            $display("FAIL mix_window: got %0d steps %0d..%0d, want 132 steps 3..134", n_int, first_int, last_int);
        end
        n_cmp++;
        if (n_done != 1 || done_k != 135) begin
            n_bad++;
            $display("FAIL done_pulse: got %0d pulses at %0d, want 1 at 135", n_done, done_k);
        end
        n_cmp++;
        if (gate_err != 0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %0d nonzero cycles, want 0", gate_err);
        end
        n_cmp++;
        if (outKeyValid !== 1'b1 || outBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL key_valid: got valid %b busy %b, want 1 0", outKeyValid, outBusy);
        end
        compute_expected(key);
        for (int k = 0; k < 44; k++) begin
            n_cmp++;
            if (m_s[k] !== exp_s[k]) begin
                n_bad++;
                $display("FAIL subkey S[%0d]: got %h, want %h", k, m_s[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int stray = 0;
        inKey = KEY3; inStart = 1'b1;
        @(negedge inClk);
        inStart = 1'b0;
        repeat (72) @(negedge inClk);
        inReset = 1'b1;
        @(negedge inClk);
        inReset = 1'b0;
        n_cmp++;
        if (outBusy !== 1'b0 || outIntWr !== 1'b0 || outKeyValid !== 1'b0 || outSvalue !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got busy %b int %b valid %b s %h, want 0 0 0 0",
                     outBusy, outIntWr, outKeyValid, outSvalue);
        end
        for (int k = 0; k < 5; k++) begin
            if (outRegClear || outExtWr || outIntWr || outDone) stray++;
            @(negedge inClk);
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: got %0d pulse cycles, want 0", stray);
        end
        run_expansion(KEY3, 0, 1'b0);
    endtask

    task automatic test_rotate_corner();
        inKey = KEY0; inStart = 1'b1;
        @(negedge inClk);
        inStart = 1'b0;
        repeat (2) @(negedge inClk);
        force_en = 1'b1;
        f_s = 32'h0; f_a = 32'h0; f_b = 32'h20; f_l = 32'h12345678;
        #1;
        n_cmp++;
        if (outSvalue !== 32'h00000100 || outLvalue !== 32'h12345798) begin
            n_bad++;
            $display("FAIL rot_amount0: got s %h l %h, want 00000100 12345798", outSvalue, outLvalue);
        end
        @(negedge inClk);
        f_s = 32'h0; f_a = 32'h0; f_b = 32'h7; f_l = 32'h80000001;
        #1;
        n_cmp++;
        if (outSvalue !== 32'h00000038 || outLvalue !== 32'h40000020) begin
            n_bad++;
            $display("FAIL rot_amount31: got s %h l %h, want 00000038 40000020", outSvalue, outLvalue);
        end
        @(negedge inClk);
        inReset = 1'b1;
        @(negedge inClk);
        inReset = 1'b0;
        force_en = 1'b0;
        @(negedge inClk);
    endtask

    initial begin
        inReset = 1'b1; inStart = 1'b0; inKey = '0;
        f_s = '0; f_l = '0; f_a = '0; f_b = '0;
        test_reset();
        test_start_under_reset();
        run_expansion(KEY0, 0, 1'b1);
        @(negedge inClk);
        run_expansion(KEY2, 53, 1'b0);
        run_expansion(KEY3, 0, 1'b0);
        test_mid_reset();
        test_rotate_corner();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
